// File: rtl/debug_step_ctrl.sv
// debug_step_ctrl: run-control master for the pipeline's PC step/enable line.
//
// Decodes command bytes from the debug UART receiver. The CPU can be run
// continuously, single-stepped or reset. The block counts stepped cycles and
// latches HALT. After every single step, and on HALT, it streams a
// {PC, cycle count} snapshot, MSB-first, through the UART transmitter.
//
// Ports:
//   i_clk, i_reset          clock; synchronous active-high reset
//   i_rx_data, i_rx_valid   received command byte and its one-cycle strobe
//   i_tx_ready              transmitter accepts o_tx_data this cycle
//   o_tx_data, o_tx_valid   byte to transmit and its valid (held until accepted)
//   i_PC                    current PC value
//   i_halt                  HALT reached writeback
//   o_Step                  registered step enable to PC and pipeline
//   o_cpu_reset             registered one-cycle pipeline reset pulse
//   o_cycles                executed-cycle counter
//   o_halted                sticky HALT flag, cleared by CPU reset
module debug_step_ctrl #(
    parameter int unsigned        NBITS     = 32,
    parameter int unsigned        NB_DATA   = 8,
    parameter logic [NB_DATA-1:0] CMD_CONT  = 8'h63,
    parameter logic [NB_DATA-1:0] CMD_STEP  = 8'h73,
    parameter logic [NB_DATA-1:0] CMD_RESET = 8'h72
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_valid,
    input  logic               i_tx_ready,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic [NBITS-1:0]   i_PC,
    input  logic               i_halt,
    output logic               o_Step,
    output logic               o_cpu_reset,
    output logic [NBITS-1:0]   o_cycles,
    output logic               o_halted
);

    localparam int unsigned NB_SNAP   = 2 * NBITS;
    localparam int unsigned NUM_BYTES = NB_SNAP / NB_DATA;
    localparam int unsigned CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StStep,
        StLoad,
        StSend,
        StDone,
        StCrst
    } state_e;

    state_e               state;
    logic [NB_SNAP-1:0]   snap;
    logic [CNT_W-1:0]     byte_cnt;
    logic                 accept;
    logic                 last_byte;
    logic                 rx_reset;

    assign accept    = o_tx_valid & i_tx_ready;
    assign last_byte = (byte_cnt == CNT_W'(NUM_BYTES - 1));
    assign rx_reset  = i_rx_valid && (i_rx_data == CMD_RESET);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= StIdle;
            o_Step      <= 1'b0;
            o_cpu_reset <= 1'b0;
            o_tx_valid  <= 1'b0;
            o_tx_data   <= '0;
            o_halted    <= 1'b0;
            o_cycles    <= '0;
            snap        <= '0;
            byte_cnt    <= '0;
        end else begin
            o_cpu_reset <= 1'b0;
            if (o_Step) begin
                o_cycles <= o_cycles + NBITS'(1);
            end

            unique case (state)
                StIdle: begin
                    if (i_rx_valid) begin
                        if (i_rx_data == CMD_CONT) begin
                            state  <= StRun;
                            o_Step <= 1'b1;
                        end else if (i_rx_data == CMD_STEP) begin
                            state  <= StStep;
                            o_Step <= 1'b1;
                        end else if (i_rx_data == CMD_RESET) begin
                            state       <= StCrst;
                            o_cpu_reset <= 1'b1;
                            o_cycles    <= '0;
                            o_halted    <= 1'b0;
                        end
                    end
                end

                StRun: begin
                    // A reset command outranks a simultaneous HALT.
                    if (rx_reset) begin
                        state       <= StCrst;
                        o_Step      <= 1'b0;
                        o_cpu_reset <= 1'b1;
                        o_cycles    <= '0;
                        o_halted    <= 1'b0;
                    end else if (i_halt) begin
                        state    <= StLoad;
                        o_Step   <= 1'b0;
                        o_halted <= 1'b1;
                    end
                end

                StStep: begin
                    state  <= StLoad;
                    o_Step <= 1'b0;
                    if (i_halt) begin
                        o_halted <= 1'b1;
                    end
                end

                StLoad: begin
                    // o_cycles already includes the final stepped cycle here.
                    snap       <= {i_PC, o_cycles};
                    o_tx_data  <= i_PC[NBITS-1 -: NB_DATA];
                    o_tx_valid <= 1'b1;
                    byte_cnt   <= '0;
                    state      <= StSend;
                end

                StSend: begin
                    if (accept) begin
                        if (last_byte) begin
                            o_tx_valid <= 1'b0;
                            state      <= o_halted ? StDone : StIdle;
                        end else begin
                            // Next byte sits just below the one being accepted.
                            byte_cnt  <= byte_cnt + CNT_W'(1);
                            snap      <= snap << NB_DATA;
                            o_tx_data <= snap[NB_SNAP-NB_DATA-1 -: NB_DATA];
                        end
                    end
                end

                StDone: begin
                    if (rx_reset) begin
                        state       <= StCrst;
                        o_cpu_reset <= 1'b1;
                        o_cycles    <= '0;
                        o_halted    <= 1'b0;
                    end
                end

                StCrst: begin
                    state <= StIdle;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Self-checking bench for debug_step_ctrl: directed command sequences with a
// PC model (PC += 4 per stepped cycle) and hand-computed byte streams.
module tb_debug_step_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [31:0] pc;
    logic        halt;
    logic        step;
    logic        cpu_rst;
    logic [31:0] cycles;
    logic        halted;

    debug_step_ctrl dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .i_tx_ready  (tx_ready),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .i_PC        (pc),
        .i_halt      (halt),
        .o_Step      (step),
        .o_cpu_reset (cpu_rst),
        .o_cycles    (cycles),
        .o_halted    (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_err = 0;

    // Observation counters, written only here; the stimulus uses differences.
    logic [7:0] tx_q[$];
    int         acc_cyc[$];
    int         cyc      = 0;
    int         step_cnt = 0;
    int         crst_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (step) step_cnt <= step_cnt + 1;
        if (cpu_rst) crst_cnt <= crst_cnt + 1;
        if (!rst && tx_valid && tx_ready) begin
            tx_q.push_back(tx_data);
            acc_cyc.push_back(cyc);
        end
    end

    // PC register model driven by the Step line.
    always @(posedge clk) begin
        if (rst || cpu_rst) pc <= 32'd0;
        else if (step) pc <= pc + 32'd4;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        halt     = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k = 0;
        while (tx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (tx_q.size() < n) check("tx_timeout", 64'(tx_q.size()), 64'(n));
    endtask

    task automatic check_stream(input string tag, input int base, input logic [63:0] exp);
        check({tag, "_count"}, 64'(tx_q.size() - base), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (base + i < tx_q.size())
                check(tag, 64'(tx_q[base+i]), 64'(exp[63-8*i -: 8]));
            else
                check(tag, 64'hdead, 64'(exp[63-8*i -: 8]));
        end
    endtask

    localparam logic [63:0] EXP_STEP = 64'h00000004_00000001;
    localparam logic [63:0] EXP_HALT = 64'h00000028_0000000A;

    initial begin
        int base;
        int sbase;
        int cbase;
        logic [7:0] eb;

        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0; halt = 1'b0;
        @(negedge clk);

        // 1: reset with random inputs, then an unknown byte.
        for (int i = 0; i < 3; i++) begin
            rx_data  = 8'($urandom);
            rx_valid = 1'($urandom);
            halt     = 1'($urandom);
            tx_ready = 1'($urandom);
            @(negedge clk);
        end
        check("rst_step", 64'(step), 64'd0);
        check("rst_cpu_reset", 64'(cpu_rst), 64'd0);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_cycles", 64'(cycles), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        rst = 1'b0; rx_valid = 1'b0; halt = 1'b0; tx_ready = 1'b1;
        sbase = step_cnt; base = tx_q.size();
        send_cmd(8'h41);
        repeat (5) @(negedge clk);
        check("junk_no_step", 64'(step_cnt - sbase), 64'd0);
        check("junk_no_tx", 64'(tx_q.size() - base), 64'd0);

        // 2: single step with ready held high.
        sbase = step_cnt; base = tx_q.size();
        send_cmd(8'h73);
        check("s_step_hi", 64'(step), 64'd1);
        @(negedge clk);
        check("s_step_lo", 64'(step), 64'd0);
        check("s_load_novalid", 64'(tx_valid), 64'd0);
        @(negedge clk);
        check("s_first_valid", 64'(tx_valid), 64'd1);
        check("s_first_byte", 64'(tx_data), 64'd0);
        wait_bytes(base + 8, 50);
        @(negedge clk);
        check("s_valid_drop", 64'(tx_valid), 64'd0);
        check_stream("s_byte", base, EXP_STEP);
        check("s_step_cycles", 64'(step_cnt - sbase), 64'd1);
        if (tx_q.size() >= base + 8)
            check("s_no_bubbles", 64'(acc_cyc[base+7] - acc_cyc[base]), 64'd7);

        // 3: single step with ready low for 5 cycles before each byte.
        do_reset();
        tx_ready = 1'b0;
        sbase = step_cnt; base = tx_q.size();
        send_cmd(8'h73);
        @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            eb = EXP_STEP[63-8*b -: 8];
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (b == 2 && k == 1) begin
                    rx_data = 8'h63; rx_valid = 1'b1;
                end else begin
                    rx_valid = 1'b0;
                end
                check("hold_valid", 64'(tx_valid), 64'd1);
                check("hold_byte", 64'(tx_data), 64'(eb));
            end
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_stream("hold_stream", base, EXP_STEP);
        check("hold_step_cycles", 64'(step_cnt - sbase), 64'd1);
        check("hold_valid_end", 64'(tx_valid), 64'd0);

        // 4: continuous run halted at cycle 9.
        do_reset();
        tx_ready = 1'b1;
        sbase = step_cnt; base = tx_q.size();
        send_cmd(8'h63);
        for (int k = 0; k < 100 && cycles != 32'd9; k++) @(negedge clk);
        check("run_reach9", 64'(cycles), 64'd9);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        check("run_step_off", 64'(step), 64'd0);
        wait_bytes(base + 8, 50);
        @(negedge clk);
        check_stream("run_byte", base, EXP_HALT);
        check("run_step_cycles", 64'(step_cnt - sbase), 64'd10);
        check("run_halted", 64'(halted), 64'd1);
        sbase = step_cnt; base = tx_q.size();
        send_cmd(8'h73);
        repeat (5) @(negedge clk);
        check("done_no_step", 64'(step_cnt - sbase), 64'd0);
        check("done_no_tx", 64'(tx_q.size() - base), 64'd0);

        // 5: CPU reset from DONE, then a normal step.
        cbase = crst_cnt;
        send_cmd(8'h72);
        check("crst_pulse", 64'(cpu_rst), 64'd1);
        check("crst_cycles", 64'(cycles), 64'd0);
        check("crst_halted", 64'(halted), 64'd0);
        repeat (3) @(negedge clk);
        check("crst_once", 64'(crst_cnt - cbase), 64'd1);
        base = tx_q.size();
        send_cmd(8'h73);
        wait_bytes(base + 8, 50);
        @(negedge clk);
        check_stream("post_crst", base, EXP_STEP);

        // 6a: i_reset in the middle of a dump.
        do_reset();
        tx_ready = 1'b1;
        base = tx_q.size();
        send_cmd(8'h73);
        wait_bytes(base + 3, 50);
        rst = 1'b1; tx_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", 64'(tx_valid), 64'd0);
        check("abort_cycles", 64'(cycles), 64'd0);
        tx_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_bytes", 64'(tx_q.size() - base), 64'd3);

        // 6b: reset command during RUN aborts without a dump.
        base = tx_q.size(); cbase = crst_cnt;
        send_cmd(8'h63);
        repeat (5) @(negedge clk);
        send_cmd(8'h72);
        check("runrst_pulse", 64'(cpu_rst), 64'd1);
        check("runrst_step", 64'(step), 64'd0);
        repeat (10) @(negedge clk);
        check("runrst_once", 64'(crst_cnt - cbase), 64'd1);
        check("runrst_cycles", 64'(cycles), 64'd0);
        check("runrst_no_tx", 64'(tx_q.size() - base), 64'd0);
        check("runrst_idle_step", 64'(step), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
